outport_uart_tx: RTL and testbench

- Downstream consumer of the processor's 32-bit output port.
- Detects every change of the output-port value and queues its low byte in a small FIFO.
- Serialises queued bytes as 8N1 UART frames on a single tx line, so program output is visible on a host terminal.
- Sits between the datapath's OutPort_output and the board's serial pin. No changes to the datapath are required.

---
 rtl/outport_uart_tx.sv | 155 +++++++++++++++
 tb/tb_outport_uart_tx.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/outport_uart_tx.sv
// Purpose: queues the low byte of every change on the 32-bit output port and sends it as an 8N1 UART frame on tx.
// Latency: byte is queued on the edge after the change, and popped on the next edge if idle; the start bit appears the cycle after the pop. A frame is 10*CLKS_PER_BIT cycles.
// Backpressure: none toward the port; a change that arrives while the FIFO is full with no pop is dropped and sets the sticky overflow flag.
module outport_uart_tx #(
    parameter int CLKS_PER_BIT = 434,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          clock,
    input  logic                          clear,
    input  logic [31:0]                   out_port,
    input  logic                          send_enable,
    output logic                          tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow
);

    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int CNT_W = AW + 1;
    localparam int CW    = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0]    LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    logic [31:0]   prev_q;
    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push;
    logic          pop;
    logic          full;
    logic          accept;

    state_t        state;
    logic [7:0]    shift;
    logic [2:0]    bit_idx;
    logic [CW-1:0] cnt;

    // Any difference in the full word counts as a new output; only the low byte is sent.
    assign push   = (out_port != prev_q) && send_enable;
    assign full   = (fifo_count == FULL_COUNT);
    // The FSM only pops from IDLE and only when something is queued.
    assign pop    = (state == IDLE) && (fifo_count != '0);
    // A pop on the same edge frees the slot, so a push into a full FIFO is still taken.
    assign accept = push && (!full || pop);

    // Track the last seen port value regardless of send_enable, so gated changes are lost.
    always_ff @(posedge clock) begin
        if (clear) begin
            prev_q <= '0;
        end else begin
            prev_q <= out_port;
        end
    end

    // Storage array needs no reset: entries are only read after being written.
    always_ff @(posedge clock) begin
        if (!clear && accept) begin
            mem[wr_ptr] <= out_port[7:0];
        end
    end

    // FIFO pointers, occupancy and sticky overflow flag.
    always_ff @(posedge clock) begin
        if (clear) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            overflow   <= 1'b0;
        end else begin
            if (accept) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({accept, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
            if (push && full && !pop) begin
                overflow <= 1'b1;
            end
        end
    end

    // Frame serialiser; tx and busy are registered so the line never glitches.
    always_ff @(posedge clock) begin
        if (clear) begin
            state   <= IDLE;
            tx      <= 1'b1;
            busy    <= 1'b0;
            cnt     <= '0;
            bit_idx <= '0;
            shift   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    tx   <= 1'b1;
                    busy <= 1'b0;
                    if (pop) begin
                        shift <= mem[rd_ptr];
                        cnt   <= '0;
                        state <= START;
                        tx    <= 1'b0;
                        busy  <= 1'b1;
                    end
                end
                START: begin
                    if (cnt == LAST) begin
                        cnt     <= '0;
                        bit_idx <= '0;
                        state   <= DATA;
                        tx      <= shift[0];
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (cnt == LAST) begin
                        cnt <= '0;
                        if (bit_idx == 3'd7) begin
                            state <= STOP;
                            tx    <= 1'b1;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                            shift   <= shift >> 1;
                            tx      <= shift[1];
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (cnt == LAST) begin
                        cnt   <= '0;
                        state <= IDLE;
                        busy  <= 1'b0;
                        tx    <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    tx    <= 1'b1;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_outport_uart_tx.sv
// Purpose: directed bench for outport_uart_tx with CLKS_PER_BIT=4, FIFO_DEPTH=4.
// Latency: samples every output 1 time unit after each rising edge.
// Backpressure: exercises FIFO full/overflow and drop behaviour.
module tb_outport_uart_tx;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;

    logic        clock;
    logic        clear;
    logic [31:0] out_port;
    logic        send_enable;
    logic        tx;
    logic        busy;
    logic [2:0]  fifo_count;
    logic        overflow;

    int n_checks;
    int n_fail;

    outport_uart_tx #(
        .CLKS_PER_BIT(CPB),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .clock      (clock),
        .clear      (clear),
        .out_port   (out_port),
        .send_enable(send_enable),
        .tx         (tx),
        .busy       (busy),
        .fifo_count (fifo_count),
        .overflow   (overflow)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    // Entry point: sampled at frame cycle first_i (cycle 0 = first start-bit cycle).
    // Exit point: the single idle cycle after the stop bit.
    task automatic check_frame(input string tag, input logic [7:0] b, input int first_i);
        logic [9:0] fr;
        fr = {1'b1, b, 1'b0};
        for (int i = first_i; i < 10 * CPB; i++) begin
            chk($sformatf("%s_tx%0d", tag, i), tx, fr[i / CPB]);
            chk($sformatf("%s_busy%0d", tag, i), busy, 1);
            step(1);
        end
        chk({tag, "_idle_busy"}, busy, 0);
        chk({tag, "_idle_tx"}, tx, 1);
    endtask

    // Watches tx for n cycles and records whether it ever dropped.
    task automatic watch_quiet(input string tag, input int n);
        logic saw_low;
        logic saw_busy;
        saw_low  = 1'b0;
        saw_busy = 1'b0;
        for (int i = 0; i < n; i++) begin
            if (tx !== 1'b1) saw_low = 1'b1;
            if (busy !== 1'b0) saw_busy = 1'b1;
            step(1);
        end
        chk({tag, "_tx_low"}, saw_low, 0);
        chk({tag, "_busy"}, saw_busy, 0);
    endtask

    initial begin
        n_checks    = 0;
        n_fail      = 0;
        clear       = 1'b1;
        out_port    = 32'hDEADBEEF;
        send_enable = 1'b1;

        // 1: reset with a nonzero port value; first edge after release queues 0xEF.
        step(2);
        chk("rst_tx", tx, 1);
        chk("rst_busy", busy, 0);
        chk("rst_count", fifo_count, 0);
        chk("rst_ovf", overflow, 0);
        clear = 1'b0;
        step(1);
        chk("rst_q_count", fifo_count, 1);
        chk("rst_q_busy", busy, 0);
        step(1);
        chk("rst_pop_count", fifo_count, 0);
        check_frame("ef", 8'hEF, 0);

        // 2: single byte 0xA5 from a steady zero port.
        send_enable = 1'b0;
        out_port    = 32'h0;
        step(1);
        send_enable = 1'b1;
        step(3);
        chk("a5_pre_count", fifo_count, 0);
        out_port = 32'h0000_00A5;
        step(1);
        chk("a5_count", fifo_count, 1);
        chk("a5_tx_before", tx, 1);
        step(1);
        chk("a5_count_pop", fifo_count, 0);
        check_frame("a5", 8'hA5, 0);

        // 3: change while gated is lost, not deferred.
        send_enable = 1'b0;
        out_port    = 32'h33;
        step(1);
        send_enable = 1'b1;
        step(1);
        chk("gate_count", fifo_count, 0);
        watch_quiet("gate", 12);
        chk("gate_count_end", fifo_count, 0);

        // 4: six changes on consecutive edges into a depth-4 FIFO.
        out_port = 32'h11; step(1);
        chk("ov_c1", fifo_count, 1);
        out_port = 32'h12; step(1);
        chk("ov_c2", fifo_count, 1);
        chk("ov_start", tx, 0);
        out_port = 32'h13; step(1);
        chk("ov_c3", fifo_count, 2);
        out_port = 32'h14; step(1);
        chk("ov_c4", fifo_count, 3);
        out_port = 32'h15; step(1);
        chk("ov_c5", fifo_count, 4);
        chk("ov_flag_pre", overflow, 0);
        out_port = 32'h16; step(1);
        chk("ov_c6", fifo_count, 4);
        chk("ov_flag", overflow, 1);
        check_frame("f11", 8'h11, 4);
        step(1); check_frame("f12", 8'h12, 0);
        step(1); check_frame("f13", 8'h13, 0);
        step(1); check_frame("f14", 8'h14, 0);
        step(1); check_frame("f15", 8'h15, 0);
        chk("ov_drained", fifo_count, 0);
        watch_quiet("ov_no16", 12);
        chk("ov_sticky", overflow, 1);

        // 5: clear during DATA bit 3 with another byte still queued.
        out_port = 32'h5A; step(1);
        chk("mid_q", fifo_count, 1);
        step(1);
        chk("mid_start", tx, 0);
        out_port = 32'h77;
        step(17);
        chk("mid_count", fifo_count, 1);
        chk("mid_bit3", tx, 1);
        chk("mid_busy", busy, 1);
        clear    = 1'b1;
        out_port = 32'h0;
        step(1);
        chk("mid_rst_tx", tx, 1);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_count", fifo_count, 0);
        chk("mid_rst_ovf", overflow, 0);
        clear = 1'b0;
        watch_quiet("mid_after", 50);
        chk("mid_after_count", fifo_count, 0);

        // 6: a change confined to bit 8 still sends the low byte 0x00.
        out_port = 32'h0000_0100;
        step(1);
        chk("up_count", fifo_count, 1);
        step(1);
        check_frame("up", 8'h00, 0);
        watch_quiet("up_after", 10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
